// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory master.
// Holds the load/store type encodings, the internal access-size codes, the
// byte-mask-per-size and word-crossing helpers, and the FSM state enum.
// No ports; imported with "import lsu_pkg::*;".
package lsu_pkg;

  // load_type encodings
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  // store_type encodings
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Internal access-size codes shared by loads and stores
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_LO = 3'd1,
    S_RSP_LO = 3'd2,
    S_REQ_HI = 3'd3,
    S_RSP_HI = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Byte mask for an access of the given size, before lane shifting
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when off + size_in_bytes > 4, i.e. the access spills into the next word
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Data-memory port between the LSU (master) and the memory controller (slave).
// Handshake: a request beat transfers in the cycle where dmem_req && dmem_gnt;
// while dmem_req is high and dmem_gnt is low, dmem_we/addr/be/wdata are held
// stable. Every granted beat gets exactly one dmem_rvalid in a later cycle
// (read data on dmem_rdata for reads, a plain ack for writes).
// Parameter: ADDR_W byte-address width.
// Signals: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata (master -> slave)
//          dmem_gnt, dmem_rvalid, dmem_rdata                 (slave -> master)
interface lsu_mem_master_if #(parameter int ADDR_W = 32);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment for the LSU.
// Ports:
//   off, size, is_unsigned : captured op attributes (byte offset, size code, zero-extend)
//   st_data                : store data, right-justified
//   rd_lo, rd_hi           : read words of the LO and HI beats (rd_hi = 0 if no HI beat)
//   be_lo, be_hi           : byte enables for the LO and HI beats
//   wdata_lo, wdata_hi     : lane-aligned write data for the LO and HI beats
//   ld_data                : extracted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] ld_data
);

  // Shifting into a double-width vector gives both beats at once: the upper
  // half equals mask >> (4 - off) and data >> 8*(4 - off), and is 0 at off = 0.
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] word;

  always_comb begin
    be_wide  = {4'b0000, size_mask(size)} << off;
    wd_wide  = {32'h0, st_data} << {off, 3'b000};
    be_lo    = be_wide[3:0];
    be_hi    = be_wide[7:4];
    wdata_lo = wd_wide[31:0];
    wdata_hi = wd_wide[63:32];
    word     = 32'({rd_hi, rd_lo} >> {off, 3'b000});
    case (size)
      SZ_B:    ld_data = {{24{~is_unsigned & word[7]}}, word[7:0]};
      SZ_H:    ld_data = {{16{~is_unsigned & word[15]}}, word[15:0]};
      default: ld_data = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Pipeline-side load/store initiator: accepts one op from the MEM stage,
// issues word-aligned byte-enabled beats on the data-memory port, waits for
// each response and returns a single wb_valid pulse with the aligned result.
// Build option: LSU_MISALIGNED_SPLIT_EN -- when defined, word-crossing ops are
// split into LO and HI beats; otherwise they complete at once with wb_err.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ex_valid/ex_ready        : op handshake (ex_ready high only in IDLE)
//   mem_read, mem_write      : op kind
//   load_type, store_type    : access type encodings (see lsu_pkg)
//   addr, rs2_data           : byte address and store data
//   wb_valid, wb_err, read_data : completion pulse, error flag, load result
//   dmem                     : data-memory master port
//   dbg_state                : current FSM state for observation
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           load_type,
  input  logic [1:0]           store_type,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          rs2_data,
  output logic                 wb_valid,
  output logic                 wb_err,
  output logic [31:0]          read_data,
  lsu_mem_master_if.master     dmem,
  output state_t               dbg_state
);

  state_t            state, state_n;
  logic              op_load, op_uns, op_err;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_data, lo_q, hi_word;

  // Decode of the op presented in IDLE
  logic       in_uns, in_illegal, in_cross, cross_err;
  logic [1:0] in_size;

  always_comb begin
    in_size = SZ_W;
    in_uns  = 1'b0;
    if (mem_read) begin
      case (load_type)
        LD_LB:   in_size = SZ_B;
        LD_LH:   in_size = SZ_H;
        LD_LBU:  begin in_size = SZ_B; in_uns = 1'b1; end
        LD_LHU:  begin in_size = SZ_H; in_uns = 1'b1; end
        default: in_size = SZ_W;
      endcase
    end else begin
      case (store_type)
        ST_SB:   in_size = SZ_B;
        ST_SH:   in_size = SZ_H;
        default: in_size = SZ_W;
      endcase
    end
    in_illegal = (mem_read && mem_write) ||
                 (mem_read && (load_type > LD_LHU)) ||
                 (mem_write && (store_type == 2'b11));
    in_cross   = crosses_word(in_size, addr[1:0]);
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic op_cross;
  logic [31:0] hi_q;
  assign cross_err = 1'b0;
  assign hi_word   = hi_q;
`else
  // Without splitting, a crossing op is rejected before any access
  assign cross_err = in_cross;
  assign hi_word   = 32'h0;
`endif

  wire accept = (state == S_IDLE) && ex_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_load <= 1'b0;
      op_uns  <= 1'b0;
      op_err  <= 1'b0;
      op_size <= SZ_W;
      op_addr <= '0;
      op_data <= 32'h0;
      lo_q    <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      op_cross <= 1'b0;
      hi_q     <= 32'h0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        op_load <= mem_read;
        op_uns  <= in_uns;
        op_err  <= in_illegal || cross_err;
        op_size <= in_size;
        op_addr <= addr;
        op_data <= rs2_data;
        lo_q    <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        op_cross <= in_cross;
        hi_q     <= 32'h0;
`endif
      end
      if ((state == S_RSP_LO) && dmem.dmem_rvalid) lo_q <= dmem.dmem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if ((state == S_RSP_HI) && dmem.dmem_rvalid) hi_q <= dmem.dmem_rdata;
`endif
    end
  end

  logic [3:0]        be_lo, be_hi;
  logic [31:0]       wdata_lo, wdata_hi, ld_data;
  logic [ADDR_W-1:0] lo_addr, hi_addr;

  assign lo_addr = {op_addr[ADDR_W-1:2], 2'b00};
  assign hi_addr = lo_addr + ADDR_W'(4);  // wraps to 0 at the top of the space

  lsu_align u_align (
    .off         (op_addr[1:0]),
    .size        (op_size),
    .is_unsigned (op_uns),
    .st_data     (op_data),
    .rd_lo       (lo_q),
    .rd_hi       (hi_word),
    .be_lo       (be_lo),
    .be_hi       (be_hi),
    .wdata_lo    (wdata_lo),
    .wdata_hi    (wdata_hi),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_n          = state;
    ex_ready         = 1'b0;
    wb_valid         = 1'b0;
    wb_err           = 1'b0;
    read_data        = 32'h0;
    dmem.dmem_req    = 1'b0;
    dmem.dmem_we     = 1'b0;
    dmem.dmem_addr   = '0;
    dmem.dmem_be     = 4'b0000;
    dmem.dmem_wdata  = 32'h0;
    case (state)
      S_IDLE: begin
        ex_ready = 1'b1;
        // An op with neither read nor write is consumed here with no response
        if (ex_valid) begin
          if (in_illegal || cross_err)   state_n = S_DONE;
          else if (mem_read || mem_write) state_n = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = ~op_load;
        dmem.dmem_addr  = lo_addr;
        dmem.dmem_be    = be_lo;
        dmem.dmem_wdata = wdata_lo;
        if (dmem.dmem_gnt) state_n = S_RSP_LO;
      end
      S_RSP_LO: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (dmem.dmem_rvalid) state_n = op_cross ? S_REQ_HI : S_DONE;
`else
        if (dmem.dmem_rvalid) state_n = S_DONE;
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ_HI: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = ~op_load;
        dmem.dmem_addr  = hi_addr;
        dmem.dmem_be    = be_hi;
        dmem.dmem_wdata = wdata_hi;
        if (dmem.dmem_gnt) state_n = S_RSP_HI;
      end
      S_RSP_HI: begin
        if (dmem.dmem_rvalid) state_n = S_DONE;
      end
`endif
      S_DONE: begin
        wb_valid  = 1'b1;
        wb_err    = op_err;
        read_data = (op_load && !op_err) ? ld_data : 32'h0;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed testbench for lsu_mem_master with a small word memory as the
// data-memory slave. Granted beats are checked against exp_q; each test task
// checks latency, wb_err and read_data against hand-computed values.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_ready, mem_read, mem_write;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr, rs2_data, read_data;
  logic        wb_valid, wb_err;
  state_t      dbg_state;

  lsu_mem_master_if #(.ADDR_W(32)) dmem_bus ();

  lsu_mem_master #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .load_type  (load_type),
    .store_type (store_type),
    .addr       (addr),
    .rs2_data   (rs2_data),
    .wb_valid   (wb_valid),
    .wb_err     (wb_err),
    .read_data  (read_data),
    .dmem       (dmem_bus.master),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- memory slave ----------------
  logic [31:0] mem [0:255];
  int          stall_left = 0;
  int          rsp_delay  = 0;
  int          req_cnt    = 0;
  logic        pend = 1'b0;
  int          pend_wait = 0;
  logic        pend_we;
  logic [31:0] pend_addr, pend_wdata;
  logic [3:0]  pend_be;

  // Expected beats {we, addr, be, wdata}
  logic [68:0] exp_q[$];

  function automatic logic [68:0] beat(input logic we, input logic [31:0] a,
                                       input logic [3:0] be, input logic [31:0] wd);
    return {we, a, be, wd};
  endfunction

  // Response / grant driver: updates just after each rising edge
  initial begin
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      dmem_bus.dmem_rvalid = 1'b0;
      dmem_bus.dmem_rdata  = 32'h0;
      if (pend) begin
        if (pend_wait == 0) begin
          pend = 1'b0;
          dmem_bus.dmem_rvalid = 1'b1;
          if (pend_we) begin
            for (int b = 0; b < 4; b++)
              if (pend_be[b]) mem[pend_addr[9:2]][8*b +: 8] = pend_wdata[8*b +: 8];
          end else begin
            dmem_bus.dmem_rdata = mem[pend_addr[9:2]];
          end
        end else begin
          pend_wait--;
        end
      end
      if (dmem_bus.dmem_req) begin
        if (stall_left > 0) begin
          dmem_bus.dmem_gnt = 1'b0;
          stall_left--;
        end else begin
          dmem_bus.dmem_gnt = 1'b1;
        end
      end else begin
        dmem_bus.dmem_gnt = 1'b0;
      end
    end
  end

  // Scoreboard: every granted beat must match the next expected beat
  initial begin
    logic [68:0] obs, exp;
    forever begin
      @(negedge clk);
      if (dmem_bus.dmem_req === 1'b1) req_cnt++;
      if (dmem_bus.dmem_req === 1'b1 && dmem_bus.dmem_gnt === 1'b1) begin
        obs = {dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata};
        pend = 1'b1; pend_wait = rsp_delay; pend_we = dmem_bus.dmem_we;
        pend_addr = dmem_bus.dmem_addr; pend_be = dmem_bus.dmem_be; pend_wdata = dmem_bus.dmem_wdata;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got %h expected none", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL beat: got %h expected %h", obs, exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rd, input logic wr, input logic [2:0] lt,
                       input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_cnt = 0;
    ex_valid = 1'b1; mem_read = rd; mem_write = wr;
    load_type = lt; store_type = st; addr = a; rs2_data = d;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Latency counted in cycles after the accept edge; -1 on timeout
  task automatic wait_wb(output int lat, output logic err, output logic [31:0] data);
    lat = -1; err = 1'b0; data = 32'h0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        lat = n; err = wb_err; data = read_data;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    load_type = 3'b0; store_type = 2'b0; addr = 32'h0; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ex_ready: got %b expected 1", ex_ready); end
    n_tests++; if (dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", dmem_bus.dmem_req); end
    n_tests++; if ({wb_valid, wb_err, read_data} !== 34'h0) begin n_fail++; $display("FAIL rst_wb: got %h expected 0", {wb_valid, wb_err, read_data}); end
    n_tests++; if ({dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata} !== 69'h0) begin
      n_fail++; $display("FAIL rst_bus: got %h expected 0", {dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata}); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, S_IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_sw_lw();
    int lat; logic err; logic [31:0] data;
    exp_q.push_back(beat(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF));
    issue(1'b0, 1'b1, 3'b0, ST_SW, 32'h100, 32'hDEADBEEF);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d expected 3", lat); end
    n_tests++; if ({err, data} !== 33'h0) begin n_fail++; $display("FAIL sw_result: got %h expected 0", {err, data}); end
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1111, 32'h0));
    issue(1'b1, 1'b0, LD_LW, 2'b0, 32'h100, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d expected 3", lat); end
    n_tests++; if (data !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h err %b expected deadbeef err 0", data, err); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sw_lw_beats: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_byte();
    int lat; logic err; logic [31:0] data;
    exp_q.push_back(beat(1'b1, 32'h100, 4'b1000, 32'h80000000));
    issue(1'b0, 1'b1, 3'b0, ST_SB, 32'h103, 32'h00000080);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 3 || err !== 1'b0) begin n_fail++; $display("FAIL sb_latency: got %0d err %b expected 3 err 0", lat, err); end
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1000, 32'h0));
    issue(1'b1, 1'b0, LD_LB, 2'b0, 32'h103, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", data); end
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1000, 32'h0));
    issue(1'b1, 1'b0, LD_LBU, 2'b0, 32'h103, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (data !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000080", data); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL byte_beats: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_halfword();
    int lat; logic err; logic [31:0] data;
    mem[8'h40] = 32'h44832211;
    exp_q.push_back(beat(1'b0, 32'h100, 4'b0110, 32'h0));
    issue(1'b1, 1'b0, LD_LH, 2'b0, 32'h101, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (data !== 32'hFFFF8322 || lat !== 3) begin n_fail++; $display("FAIL lh_data: got %h lat %0d expected ffff8322 lat 3", data, lat); end
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1100, 32'h0));
    issue(1'b1, 1'b0, LD_LHU, 2'b0, 32'h102, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (data !== 32'h00004483) begin n_fail++; $display("FAIL lhu_data: got %h expected 00004483", data); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL half_beats: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_cross();
    int lat; logic err; logic [31:0] data;
    mem[8'h40] = 32'h44332211;
    mem[8'h41] = 32'h88776655;
    mem[8'hFF] = 32'hAB000000;
    mem[8'h00] = 32'h000000CD;
`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1100, 32'h0));
    exp_q.push_back(beat(1'b0, 32'h104, 4'b0011, 32'h0));
    issue(1'b1, 1'b0, LD_LW, 2'b0, 32'h102, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL cross_lw_latency: got %0d expected 5", lat); end
    n_tests++; if (data !== 32'h66554433 || err !== 1'b0) begin n_fail++; $display("FAIL cross_lw_data: got %h err %b expected 66554433 err 0", data, err); end
    exp_q.push_back(beat(1'b1, 32'h100, 4'b1000, 32'hEF000000));
    exp_q.push_back(beat(1'b1, 32'h104, 4'b0001, 32'h000000BE));
    issue(1'b0, 1'b1, 3'b0, ST_SH, 32'h103, 32'h0000BEEF);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 5 || err !== 1'b0) begin n_fail++; $display("FAIL cross_sh: got lat %0d err %b expected 5 err 0", lat, err); end
    exp_q.push_back(beat(1'b0, 32'hFFFFFFFC, 4'b1000, 32'h0));
    exp_q.push_back(beat(1'b0, 32'h00000000, 4'b0001, 32'h0));
    issue(1'b1, 1'b0, LD_LH, 2'b0, 32'hFFFFFFFF, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (data !== 32'hFFFFCDAB || lat !== 5) begin n_fail++; $display("FAIL wrap_lh: got %h lat %0d expected ffffcdab lat 5", data, lat); end
`else
    issue(1'b1, 1'b0, LD_LW, 2'b0, 32'h102, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL cross_lw_err: got lat %0d err %b expected 1 err 1", lat, err); end
    n_tests++; if (data !== 32'h0 || req_cnt != 0) begin n_fail++; $display("FAIL cross_lw_noreq: got data %h reqs %0d expected 0 0", data, req_cnt); end
    issue(1'b1, 1'b0, LD_LH, 2'b0, 32'hFFFFFFFF, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 1 || err !== 1'b1 || req_cnt != 0) begin n_fail++; $display("FAIL wrap_lh_err: got lat %0d err %b reqs %0d expected 1 1 0", lat, err, req_cnt); end
`endif
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cross_beats: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int lat; int bad; logic [31:0] data;
    mem[8'h40] = 32'h11223344;
    stall_left = 3;
    bad = 0; lat = -1; data = 32'h0;
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1111, 32'h0));
    issue(1'b1, 1'b0, LD_LW, 2'b0, 32'h100, 32'h0);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n <= 3 && !(dmem_bus.dmem_req === 1'b1 && dmem_bus.dmem_addr === 32'h100 &&
                      dmem_bus.dmem_be === 4'b1111 && dmem_bus.dmem_we === 1'b0 &&
                      dmem_bus.dmem_wdata === 32'h0 && ex_ready === 1'b0)) bad++;
      if (wb_valid === 1'b1) begin lat = n; data = read_data; end
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL stall_latency: got %0d expected 6", lat); end
    n_tests++; if (data !== 32'h11223344) begin n_fail++; $display("FAIL stall_data: got %h expected 11223344", data); end
  endtask

  task automatic test_illegal();
    int lat; logic err; logic [31:0] data;
    issue(1'b1, 1'b0, 3'b111, 2'b0, 32'h100, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL ill_lt: got lat %0d err %b expected 1 err 1", lat, err); end
    n_tests++; if (data !== 32'h0 || req_cnt != 0) begin n_fail++; $display("FAIL ill_lt_noreq: got data %h reqs %0d expected 0 0", data, req_cnt); end
    issue(1'b1, 1'b1, LD_LW, ST_SW, 32'h100, 32'h12345678);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 1 || err !== 1'b1 || req_cnt != 0) begin n_fail++; $display("FAIL ill_rw: got lat %0d err %b reqs %0d expected 1 1 0", lat, err, req_cnt); end
    issue(1'b0, 1'b1, 3'b0, 2'b11, 32'h100, 32'h12345678);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 1 || err !== 1'b1 || req_cnt != 0) begin n_fail++; $display("FAIL ill_st: got lat %0d err %b reqs %0d expected 1 1 0", lat, err, req_cnt); end
  endtask

  task automatic test_nop();
    int bad;
    bad = 0;
    issue(1'b0, 1'b0, LD_LW, ST_SW, 32'h100, 32'h0);
    repeat (6) begin
      @(negedge clk);
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || dmem_bus.dmem_req !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL nop_consumed: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad; int lat; logic err; logic [31:0] data;
    bad = 0;
    rsp_delay = 1;
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1111, 32'h0));
    issue(1'b1, 1'b0, LD_LW, 2'b0, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (dbg_state !== S_RSP_LO) begin n_fail++; $display("FAIL mid_state: got %0d expected %0d", dbg_state, S_RSP_LO); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (dmem_bus.dmem_req !== 1'b0 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_rst: got req %b ready %b expected 0 1", dmem_bus.dmem_req, ex_ready); end
    if (wb_valid !== 1'b0) bad++;
    repeat (6) begin
      @(negedge clk);
      if (wb_valid !== 1'b0 || dbg_state !== S_IDLE) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_wb: got %0d bad cycles expected 0", bad); end
    rsp_delay = 0;
    exp_q.push_back(beat(1'b0, 32'h100, 4'b1111, 32'h0));
    issue(1'b1, 1'b0, LD_LW, 2'b0, 32'h100, 32'h0);
    wait_wb(lat, err, data);
    n_tests++; if (lat !== 3 || data !== 32'h11223344) begin n_fail++; $display("FAIL mid_recover: got lat %0d data %h expected 3 11223344", lat, data); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_beats: got %0d pending expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_sw_lw();
    test_byte();
    test_halfword();
    test_cross();
    test_stall();
    test_illegal();
    test_nop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
